// File: rtl/alu_exec_if.sv
// Execute-stage ALU bus: operand/opcode inputs, combinational result,
// HI/LO registers, and the mult/div busy/done handshake.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    // Handshake: a mult/div launches on a clock edge where start=1,
    // flush=0, the op is MULT/DIV and busy=0; busy holds until the
    // result lands in Hi/Lo, and done pulses for the one cycle after that.
    logic             start;
    logic             flush;
    logic [3:0]       ALU_Control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    modport master (
        output start, flush, ALU_Control, A, B, shamt,
        input  Result, Zero, Hi, Lo, busy, done, dbg_state
    );

    modport slave (
        input  start, flush, ALU_Control, A, B, shamt,
        output Result, Zero, Hi, Lo, busy, done, dbg_state
    );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// signed MULT/DIV unit (WIDTH iterations) writing the HI/LO registers.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_exec_if.slave  bus
);
    localparam int         CW      = $clog2(WIDTH) + 1;
    localparam logic [3:0] OP_MULT = 4'b0101;
    localparam logic [3:0] OP_DIV  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_op_div;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH-1:0]   w_result;
    logic               w_launch;
    logic               w_write;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_fin;
    logic [WIDTH-1:0]   w_lo_fin;

    always_comb begin
        w_result = '0;
        case (bus.ALU_Control)
            4'b0000: w_result = bus.A & bus.B;
            4'b0001: w_result = bus.A | bus.B;
            4'b0010: w_result = bus.A + bus.B;
            4'b0110: w_result = bus.A - bus.B;
            4'b1100: w_result = ~(bus.A | bus.B);
            4'b0100: w_result = bus.A ^ bus.B;
            4'b0111: w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            4'b1000: w_result = bus.B << bus.shamt;
            4'b1001: w_result = bus.B >> bus.shamt;
            4'b1010: w_result = WIDTH'($signed(bus.B) >>> bus.shamt);
            default: w_result = '0;
        endcase
    end

    assign bus.Result    = w_result;
    assign bus.Zero      = (w_result == '0);
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

    assign w_launch = (r_state == S_IDLE) && bus.start && !bus.flush &&
                      ((bus.ALU_Control == OP_MULT) || (bus.ALU_Control == OP_DIV));
    assign w_write  = (r_state == S_FIN) && !bus.flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next = S_RUN;
            S_RUN: begin
                if (bus.flush)                          w_next = S_IDLE;
                else if (r_cnt == CW'(WIDTH - 1))       w_next = S_FIN;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    assign w_abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign w_abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;

    // Multiply: r_acc = {partial, multiplier}, add in the top half then shift
    // right. Divide: r_acc = {remainder, dividend/quotient}, shift left and
    // keep the trial subtraction only if it does not borrow.
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_opnd};

    always_comb begin
        if (!r_op_div)
            w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        else if (w_diff[WIDTH+1])
            w_acc_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        else
            w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end

    assign w_prod = r_sign_q ? -r_acc : r_acc;
    assign w_quot = r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_sign_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fin = w_prod[WIDTH-1:0];
        if (r_op_div) begin
            w_hi_fin = r_b_zero ? r_a_raw : w_rem;
            w_lo_fin = r_b_zero ? '1      : w_quot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_a_raw  <= '0;
            r_op_div <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_b_zero <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_write;
            if (w_launch) begin
                r_op_div <= (bus.ALU_Control == OP_DIV);
                r_opnd   <= (bus.ALU_Control == OP_DIV) ? w_abs_b : w_abs_a;
                r_acc    <= {{WIDTH{1'b0}}, ((bus.ALU_Control == OP_DIV) ? w_abs_a : w_abs_b)};
                r_a_raw  <= bus.A;
                r_sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                r_sign_r <= bus.A[WIDTH-1];
                r_b_zero <= (bus.B == '0);
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_write) begin
                r_hi <= w_hi_fin;
                r_lo <= w_lo_fin;
            end
        end
    end
endmodule
